// File: rtl/gpio_input_filter.sv
// Synchronises and glitch-filters raw GPIO pin levels, keeps sticky edge flags and exposes them
// on the bus at 0x1200..0x12FF. Define GPIO_IN_IRQ_EN to add mask registers and irq_o.
module gpio_input_filter #(
  parameter int unsigned AddrWidth     = 16,
  parameter int unsigned BusWidth      = 32,
  parameter int unsigned GPIOWidth     = 36,
  parameter int unsigned NumGPIO       = 2,
  parameter int unsigned NumInReg      = 3,
  parameter int unsigned FilterWidth   = 8,
  parameter int unsigned FilterDefault = 4
) (
  input  logic                              reg_clk,
  input  logic                              reset_in,
  input  logic                              chip_sel,
  input  logic                              write_reg,
  input  logic                              read_reg,
  input  logic [AddrWidth-3:0]              busaddress,
  input  logic [BusWidth-1:0]               busdata_in,
  input  logic [NumGPIO-1:0][GPIOWidth-1:0] io_read_data,
  output logic [NumGPIO-1:0][GPIOWidth-1:0] filtered_data,
  output logic [BusWidth-1:0]               busdata_out,
  output logic                              read_hit
`ifdef GPIO_IN_IRQ_EN
  ,
  output logic                              irq_o
`endif
);

  localparam int unsigned NumPins = NumGPIO * GPIOWidth;
  localparam int unsigned RegPins = NumInReg * 24;
  localparam logic [FilterWidth-1:0] CntMax = '1;

  // Bus stage 1 registers
  logic                 cs_q, rd_q, wr_q;
  logic [AddrWidth-3:0] waddr_q;
  logic [23:0]          wdata_q;

  // Decoded stage-2 access
  logic       in_range;
  logic [3:0] cls;
  logic [1:0] idx;
  logic       rd_en, wr_en;

  // Per-pin state
  logic [NumPins-1:0]                  pins_raw;
  logic [NumPins-1:0]                  sync1_q, sync_q;
  logic [NumPins-1:0]                  filt_q, filt_d;
  logic [NumPins-1:0][FilterWidth-1:0] cnt_q, cnt_d;
  logic [NumPins-1:0]                  rise_q, rise_d, fall_q, fall_d;
  logic [NumPins-1:0]                  rise_clr, fall_clr;
  logic [FilterWidth-1:0]              filter_len_q, filter_len_d;

  // Read path
  logic [RegPins-1:0]  filt_pad, rise_pad, fall_pad;
  logic [23:0]         rd_word;
  logic [BusWidth-1:0] rdata;
  logic [BusWidth-1:0] busdata_q, busdata_d;
  logic                read_hit_q, read_hit_d;

  logic unused_bits;
  assign unused_bits = ^busdata_in[BusWidth-1:24];

  assign pins_raw = io_read_data;

  always_ff @(posedge reg_clk or posedge reset_in) begin
    if (reset_in) begin
      cs_q    <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      cs_q    <= chip_sel;
      rd_q    <= read_reg;
      wr_q    <= write_reg;
      waddr_q <= busaddress;
      wdata_q <= busdata_in[23:0];
    end
  end

  // Word address bits [AddrWidth-3:6] are byte address bits [AddrWidth-1:8]
  assign in_range = (waddr_q[AddrWidth-3:6] == (AddrWidth-8)'('h12));
  assign cls      = waddr_q[5:2];
  assign idx      = waddr_q[1:0];
  assign rd_en    = cs_q & rd_q;
  assign wr_en    = cs_q & wr_q & in_range;

  always_comb begin
    filt_d = filt_q;
    cnt_d  = cnt_q;
    for (int unsigned f = 0; f < NumPins; f++) begin
      if (sync_q[f] == filt_q[f]) begin
        cnt_d[f] = '0;
      end else if (cnt_q[f] >= filter_len_q) begin
        filt_d[f] = sync_q[f];
        cnt_d[f]  = '0;
      end else if (cnt_q[f] != CntMax) begin
        cnt_d[f] = cnt_q[f] + 1'b1;
      end
    end
  end

  always_comb begin
    rise_clr = '0;
    fall_clr = '0;
    for (int unsigned f = 0; f < NumPins; f++) begin
      if (wr_en && 32'(idx) == f / 24) begin
        if (cls == 4'h1) rise_clr[f] = wdata_q[f % 24];
        if (cls == 4'h2) fall_clr[f] = wdata_q[f % 24];
      end
    end
  end

  // A new edge in the same cycle as its W1C keeps the flag set
  assign rise_d = (rise_q & ~rise_clr) | (filt_d & ~filt_q);
  assign fall_d = (fall_q & ~fall_clr) | (~filt_d & filt_q);

  always_comb begin
    filter_len_d = filter_len_q;
    if (wr_en && cls == 4'h3 && idx == 2'd0) begin
      filter_len_d = wdata_q[FilterWidth-1:0];
    end
  end

  always_ff @(posedge reg_clk or posedge reset_in) begin
    if (reset_in) begin
      sync1_q      <= '0;
      sync_q       <= '0;
      filt_q       <= '0;
      cnt_q        <= '0;
      rise_q       <= '0;
      fall_q       <= '0;
      filter_len_q <= FilterWidth'(FilterDefault);
    end else begin
      sync1_q      <= pins_raw;
      sync_q       <= sync1_q;
      filt_q       <= filt_d;
      cnt_q        <= cnt_d;
      rise_q       <= rise_d;
      fall_q       <= fall_d;
      filter_len_q <= filter_len_d;
    end
  end

`ifdef GPIO_IN_IRQ_EN
  logic [NumPins-1:0] mask_q, mask_d;
  logic [RegPins-1:0] mask_pad;
  logic               irq_q;

  always_comb begin
    mask_d = mask_q;
    for (int unsigned f = 0; f < NumPins; f++) begin
      if (wr_en && cls == 4'h4 && 32'(idx) == f / 24) mask_d[f] = wdata_q[f % 24];
    end
  end

  always_ff @(posedge reg_clk or posedge reset_in) begin
    if (reset_in) begin
      mask_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      mask_q <= mask_d;
      irq_q  <= |((rise_q | fall_q) & mask_q);
    end
  end

  assign irq_o = irq_q;
`endif

  // Zero-extend pin vectors to whole 24-bit register slices
  for (genvar i = 0; i < RegPins; i++) begin : g_pad
    if (i < NumPins) begin : g_pin
      assign filt_pad[i] = filt_q[i];
      assign rise_pad[i] = rise_q[i];
      assign fall_pad[i] = fall_q[i];
`ifdef GPIO_IN_IRQ_EN
      assign mask_pad[i] = mask_q[i];
`endif
    end else begin : g_zero
      assign filt_pad[i] = 1'b0;
      assign rise_pad[i] = 1'b0;
      assign fall_pad[i] = 1'b0;
`ifdef GPIO_IN_IRQ_EN
      assign mask_pad[i] = 1'b0;
`endif
    end
  end

  always_comb begin
    rd_word = '0;
    for (int unsigned k = 0; k < NumInReg; k++) begin
      if (32'(idx) == k) begin
        case (cls)
          4'h0: rd_word = filt_pad[24*k +: 24];
          4'h1: rd_word = rise_pad[24*k +: 24];
          4'h2: rd_word = fall_pad[24*k +: 24];
`ifdef GPIO_IN_IRQ_EN
          4'h4: rd_word = mask_pad[24*k +: 24];
`endif
          default: rd_word = '0;
        endcase
      end
    end
    rdata = '0;
    if (in_range) begin
      rdata = BusWidth'(rd_word);
      if (cls == 4'h3 && idx == 2'd0) rdata = BusWidth'(filter_len_q);
    end
  end

  // Read data holds until the next valid read
  always_comb begin
    busdata_d  = busdata_q;
    read_hit_d = read_hit_q;
    if (rd_en) begin
      busdata_d  = rdata;
      read_hit_d = in_range;
    end
  end

  always_ff @(posedge reg_clk or posedge reset_in) begin
    if (reset_in) begin
      busdata_q  <= '0;
      read_hit_q <= 1'b0;
    end else begin
      busdata_q  <= busdata_d;
      read_hit_q <= read_hit_d;
    end
  end

  assign filtered_data = filt_q;
  assign busdata_out   = busdata_q;
  assign read_hit      = read_hit_q;

endmodule

// File: tb/tb_gpio_input_filter.sv
// Directed and randomized bench for gpio_input_filter with a run-length based reference model.
module tb_gpio_input_filter;

  localparam int NG = 2;
  localparam int GW = 36;
  localparam int NP = NG * GW;
  localparam int NR = 3;

  logic                   reg_clk = 1'b0;
  logic                   reset_in;
  logic                   chip_sel, write_reg, read_reg;
  logic [13:0]            busaddress;
  logic [31:0]            busdata_in;
  logic [NG-1:0][GW-1:0]  io_read_data;
  logic [NG-1:0][GW-1:0]  filtered_data;
  logic [31:0]            busdata_out;
  logic                   read_hit;
`ifdef GPIO_IN_IRQ_EN
  logic                   irq_o;
`endif

  gpio_input_filter dut (
    .reg_clk      (reg_clk),
    .reset_in     (reset_in),
    .chip_sel     (chip_sel),
    .write_reg    (write_reg),
    .read_reg     (read_reg),
    .busaddress   (busaddress),
    .busdata_in   (busdata_in),
    .io_read_data (io_read_data),
    .filtered_data(filtered_data),
    .busdata_out  (busdata_out),
    .read_hit     (read_hit)
`ifdef GPIO_IN_IRQ_EN
    ,
    .irq_o        (irq_o)
`endif
  );

  always #5 reg_clk = ~reg_clk;

  int n_assert;
  int n_fail;

  // Reference model state
  logic [NP-1:0] m_filt, m_rise, m_fall, m_mask;
  logic [NP-1:0] m_pin1, m_pin2;  // pin levels seen one and two edges ago
  int            m_run[NP];       // consecutive synced samples disagreeing with m_filt
  int            m_len;
  logic [31:0]   m_bdo;
  logic          m_hit, m_irq;
  logic          p_cs, p_rd, p_wr;
  logic [15:0]   p_addr;
  logic [31:0]   p_data;

  logic [15:0]   addrs[8];

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    m_filt = '0; m_rise = '0; m_fall = '0; m_mask = '0;
    m_pin1 = '0; m_pin2 = '0;
    for (int f = 0; f < NP; f++) m_run[f] = 0;
    m_len = 4; m_bdo = '0; m_hit = 1'b0; m_irq = 1'b0;
    p_cs = 1'b0; p_rd = 1'b0; p_wr = 1'b0; p_addr = '0; p_data = '0;
  endfunction

  function automatic void model_read(input logic [15:0] a, output logic hit,
                                     output logic [31:0] d);
    int          cls;
    int          k;
    logic [95:0] v;
    hit = (a[15:8] == 8'h12);
    d   = '0;
    cls = int'(a[7:4]);
    k   = int'(a[3:2]);
    if (hit) begin
      if (cls <= 2 && k < NR) begin
        v = (cls == 0) ? 96'(m_filt) : (cls == 1) ? 96'(m_rise) : 96'(m_fall);
        d = {8'h00, v[24*k +: 24]};
      end
      if (cls == 3 && k == 0) d = 32'(m_len);
`ifdef GPIO_IN_IRQ_EN
      if (cls == 4 && k < NR) begin
        v = 96'(m_mask);
        d = {8'h00, v[24*k +: 24]};
      end
`endif
    end
  endfunction

  // One clock: snapshot inputs, advance the model across the edge, compare 1 time unit later
  task automatic tick();
    logic [NP-1:0] pin_now, samp, set_r, set_f, clr_r, clr_f;
    logic          cs, rd, wr, irq_next;
    logic [15:0]   a;
    logic [31:0]   d;
    int            cls, k;
    pin_now = io_read_data;
    cs = chip_sel; rd = read_reg; wr = write_reg;
    a = {busaddress, 2'b00}; d = busdata_in;
    @(posedge reg_clk);
    irq_next = |((m_rise | m_fall) & m_mask);
    if (p_cs && p_rd) model_read(p_addr, m_hit, m_bdo);
    samp = m_pin2;
    set_r = '0; set_f = '0; clr_r = '0; clr_f = '0;
    for (int f = 0; f < NP; f++) begin
      if (samp[f] != m_filt[f]) begin
        m_run[f]++;
        if (m_run[f] >= m_len + 1) begin
          m_filt[f] = samp[f];
          m_run[f]  = 0;
          if (samp[f]) set_r[f] = 1'b1;
          else set_f[f] = 1'b1;
        end
      end else begin
        m_run[f] = 0;
      end
    end
    if (p_cs && p_wr && p_addr[15:8] == 8'h12) begin
      cls = int'(p_addr[7:4]);
      k   = int'(p_addr[3:2]);
      for (int f = 0; f < NP; f++) begin
        if (f / 24 == k) begin
          if (cls == 1) clr_r[f] = p_data[f % 24];
          if (cls == 2) clr_f[f] = p_data[f % 24];
`ifdef GPIO_IN_IRQ_EN
          if (cls == 4) m_mask[f] = p_data[f % 24];
`endif
        end
      end
      if (cls == 3 && k == 0) m_len = int'(p_data[7:0]);
    end
    m_rise = (m_rise & ~clr_r) | set_r;
    m_fall = (m_fall & ~clr_f) | set_f;
    m_pin2 = m_pin1;
    m_pin1 = pin_now;
    p_cs = cs; p_rd = rd; p_wr = wr; p_addr = a; p_data = d;
    m_irq = irq_next;
    #1;
    check("filtered_data", 96'(filtered_data), 96'(m_filt));
    check("busdata_out", 96'(busdata_out), 96'(m_bdo));
    check("read_hit", 96'(read_hit), 96'(m_hit));
`ifdef GPIO_IN_IRQ_EN
    check("irq_o", 96'(irq_o), 96'(m_irq));
`endif
  endtask

  task automatic bus(input logic rd, input logic wr, input logic [15:0] a, input logic [31:0] d);
    chip_sel = 1'b1; read_reg = rd; write_reg = wr;
    busaddress = a[15:2]; busdata_in = d;
    tick();
    chip_sel = 1'b0; read_reg = 1'b0; write_reg = 1'b0;
    busaddress = 14'($urandom); busdata_in = $urandom;
  endtask

  task automatic rd_chk(input string tag, input logic [15:0] a, input logic [31:0] exp_d,
                        input logic exp_hit);
    bus(1'b1, 1'b0, a, 32'h0);
    tick();
    check(tag, 96'(busdata_out), 96'(exp_d));
    check({tag, "_hit"}, 96'(read_hit), 96'(exp_hit));
  endtask

  initial begin
    logic [NP-1:0] flat;
    int            op;
    logic [15:0]   ra;
    n_assert = 0; n_fail = 0;
    addrs[0] = 16'h1200; addrs[1] = 16'h1210; addrs[2] = 16'h1220; addrs[3] = 16'h1230;
    addrs[4] = 16'h1240; addrs[5] = 16'h1250; addrs[6] = 16'h1100; addrs[7] = 16'h12f0;
    chip_sel = 1'b0; write_reg = 1'b0; read_reg = 1'b0;
    busaddress = '0; busdata_in = '0; io_read_data = '0;
    reset_in = 1'b1;
    model_reset();
    repeat (2) @(posedge reg_clk);
    #1;
    check("rst_filtered", 96'(filtered_data), 96'h0);
    check("rst_busdata", 96'(busdata_out), 96'h0);
    check("rst_hit", 96'(read_hit), 96'h0);
    reset_in = 1'b0;

    // Default filter length readback
    rd_chk("len_default", 16'h1230, 32'h4, 1'b1);

    // Short pulse on f=5 is rejected, then a held level passes after 7 edges
    io_read_data[0][5] = 1'b1;
    repeat (3) tick();
    io_read_data[0][5] = 1'b0;
    repeat (8) tick();
    check("pulse_reject", 96'(filtered_data[0][5]), 96'h0);
    io_read_data[0][5] = 1'b1;
    repeat (6) tick();
    check("rise_edge6", 96'(filtered_data[0][5]), 96'h0);
    tick();
    check("rise_edge7", 96'(filtered_data[0][5]), 96'h1);
    rd_chk("filt_1200", 16'h1200, 32'h20, 1'b1);
    rd_chk("rise_1210", 16'h1210, 32'h20, 1'b1);

    // filter_len=0: f=40 follows with 3-edge latency
    bus(1'b0, 1'b1, 16'h1230, 32'h0);
    tick();
    io_read_data[1][4] = 1'b1;
    repeat (2) tick();
    check("f40_hi_edge2", 96'(filtered_data[1][4]), 96'h0);
    tick();
    check("f40_hi_edge3", 96'(filtered_data[1][4]), 96'h1);
    rd_chk("filt_1204", 16'h1204, 32'h00010000, 1'b1);
    repeat (5) tick();
    io_read_data[1][4] = 1'b0;
    repeat (2) tick();
    check("f40_lo_edge2", 96'(filtered_data[1][4]), 96'h1);
    tick();
    check("f40_lo_edge3", 96'(filtered_data[1][4]), 96'h0);
    repeat (7) tick();
    rd_chk("rise_1214", 16'h1214, 32'h00010000, 1'b1);
    rd_chk("fall_1224", 16'h1224, 32'h00010000, 1'b1);

    // W1C racing a new rise: the set wins
    bus(1'b0, 1'b1, 16'h1210, 32'h20);
    tick();
    rd_chk("w1c_clear", 16'h1210, 32'h0, 1'b1);
    io_read_data[0][5] = 1'b0;
    repeat (4) tick();
    io_read_data[0][5] = 1'b1;
    tick();
    bus(1'b0, 1'b1, 16'h1210, 32'h20);
    tick();
    check("race_filt", 96'(filtered_data[0][5]), 96'h1);
    rd_chk("race_set_wins", 16'h1210, 32'h20, 1'b1);
    bus(1'b0, 1'b1, 16'h1210, 32'h20);
    tick();
    rd_chk("w1c_again", 16'h1210, 32'h0, 1'b1);

    // Out-of-range and unmapped in-range reads
    rd_chk("rd_1100", 16'h1100, 32'h0, 1'b0);
    rd_chk("rd_1250", 16'h1250, 32'h0, 1'b1);
    rd_chk("rd_1240", 16'h1240, 32'h0, 1'b1);

    // Simultaneous read and write returns the pre-write value
    bus(1'b1, 1'b1, 16'h1230, 32'h7);
    tick();
    check("rdwr_old", 96'(busdata_out), 96'h0);
    rd_chk("rdwr_new", 16'h1230, 32'h7, 1'b1);
    bus(1'b0, 1'b1, 16'h1230, 32'h0);
    tick();

`ifdef GPIO_IN_IRQ_EN
    bus(1'b0, 1'b1, 16'h1240, 32'h20);
    tick();
    io_read_data[0][5] = 1'b0;
    repeat (4) tick();
    bus(1'b0, 1'b1, 16'h1220, 32'h20);
    tick();
    tick();
    check("irq_cleared", 96'(irq_o), 96'h0);
    io_read_data[0][5] = 1'b1;
    repeat (4) tick();
    check("irq_rise", 96'(irq_o), 96'h1);
    bus(1'b0, 1'b1, 16'h1210, 32'h20);
    tick();
    check("irq_lag", 96'(irq_o), 96'h1);
    tick();
    check("irq_low", 96'(irq_o), 96'h0);
`endif

    // Reset with a write in flight drops the write
    bus(1'b0, 1'b1, 16'h1230, 32'h9);
    reset_in = 1'b1;
    #1;
    model_reset();
    check("midrst_filtered", 96'(filtered_data), 96'h0);
    check("midrst_busdata", 96'(busdata_out), 96'h0);
    @(posedge reg_clk);
    #1;
    reset_in = 1'b0;
    rd_chk("midrst_len", 16'h1230, 32'h4, 1'b1);

    // Randomized traffic against the model
    for (int c = 0; c < 2000; c++) begin
      flat = io_read_data;
      for (int f = 0; f < NP; f++) begin
        if ($urandom_range(15) == 0) flat[f] = ~flat[f];
      end
      io_read_data = flat;
      op = int'($urandom_range(11));
      ra = addrs[$urandom_range(7)] + 16'(4 * $urandom_range(3));
      case (op)
        0, 1, 2: bus(1'b1, 1'b0, ra, 32'h0);
        3: bus(1'b0, 1'b1, ($urandom_range(1) == 0) ? 16'h1210 + 16'(4 * $urandom_range(2))
                                                      : 16'h1220 + 16'(4 * $urandom_range(2)),
               $urandom);
        4: bus(1'b0, 1'b1, 16'h1230, 32'($urandom_range(6)) | ($urandom & 32'hffffff00));
        5: bus(1'b1, 1'b1, ra, $urandom);
        6: bus(1'b0, 1'b1, 16'h1240 + 16'(4 * $urandom_range(2)), $urandom);
        7: begin
          chip_sel = 1'b0; read_reg = 1'b1; write_reg = 1'b1;
          busaddress = 14'h0488; busdata_in = $urandom;
          tick();
          read_reg = 1'b0; write_reg = 1'b0;
        end
        default: tick();
      endcase
    end
    repeat (12) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
